// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibits the bus, requests to send,
// shifts {stop, parity, data} out on device clock falls, then checks the ACK.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned RTS_CYCLES     = 100,
  parameter int unsigned TIMEOUT_CYCLES = 750000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_data,
  input  logic       i_valid,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_error,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic       o_ps2_clk_oe,
  output logic       o_ps2_data_oe
);

  localparam int unsigned PHASE_MAX = (INHIBIT_CYCLES > RTS_CYCLES) ? INHIBIT_CYCLES : RTS_CYCLES;
  localparam int unsigned CNT_W     = $clog2(PHASE_MAX + 1);
  localparam int unsigned TO_W      = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned FRAME_W   = 10;
  localparam int unsigned BIT_W     = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_RTS,
    S_SEND,
    S_ACK,
    S_WAIT_IDLE
  } state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [TO_W-1:0]    tcnt, tcnt_n;
  logic [BIT_W-1:0]   bit_cnt, bit_n;
  logic [FRAME_W-1:0] frame, frame_n;
  logic               clk_oe_n, data_oe_n, done_n, error_n, busy_n;
  logic               clk_s1, clk_s2, clk_prev, dat_s1, dat_s2;
  logic               fall, to_hit;

  assign fall   = clk_prev & ~clk_s2;
  assign to_hit = (tcnt == TO_W'(TIMEOUT_CYCLES - 1));

  // Next-state and next-output logic; outputs are registered from the *_n values.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    tcnt_n    = tcnt;
    bit_n     = bit_cnt;
    frame_n   = frame;
    clk_oe_n  = o_ps2_clk_oe;
    data_oe_n = o_ps2_data_oe;
    done_n    = 1'b0;
    error_n   = 1'b0;

    case (state)
      S_IDLE: begin
        clk_oe_n  = 1'b0;
        data_oe_n = 1'b0;
        if (i_valid) begin
          frame_n  = {1'b1, ~^i_data, i_data};
          cnt_n    = '0;
          tcnt_n   = '0;
          bit_n    = '0;
          clk_oe_n = 1'b1;
          state_n  = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        cnt_n = CNT_W'(cnt + 1'b1);
        if (cnt == CNT_W'(INHIBIT_CYCLES - 1)) begin
          cnt_n     = '0;
          data_oe_n = 1'b1;
          state_n   = S_RTS;
        end
      end
      S_RTS: begin
        cnt_n = CNT_W'(cnt + 1'b1);
        if (cnt == CNT_W'(RTS_CYCLES - 1)) begin
          cnt_n    = '0;
          clk_oe_n = 1'b0;
          bit_n    = '0;
          tcnt_n   = '0;
          state_n  = S_SEND;
        end
      end
      S_SEND: begin
        if (fall) begin
          tcnt_n = '0;
          bit_n  = BIT_W'(bit_cnt + 1'b1);
          if (bit_cnt == BIT_W'(FRAME_W - 1)) begin
            data_oe_n = 1'b0;
            state_n   = S_ACK;
          end else begin
            data_oe_n = ~frame[bit_cnt];
          end
        end else if (to_hit) begin
          clk_oe_n  = 1'b0;
          data_oe_n = 1'b0;
          error_n   = 1'b1;
          state_n   = S_IDLE;
        end else begin
          tcnt_n = TO_W'(tcnt + 1'b1);
        end
      end
      S_ACK: begin
        if (fall) begin
          tcnt_n = '0;
          if (!dat_s2) begin
            state_n = S_WAIT_IDLE;
          end else begin
            error_n = 1'b1;
            state_n = S_IDLE;
          end
        end else if (to_hit) begin
          clk_oe_n  = 1'b0;
          data_oe_n = 1'b0;
          error_n   = 1'b1;
          state_n   = S_IDLE;
        end else begin
          tcnt_n = TO_W'(tcnt + 1'b1);
        end
      end
      S_WAIT_IDLE: begin
        if (clk_s2 && dat_s2) begin
          done_n  = 1'b1;
          state_n = S_IDLE;
        end else if (fall) begin
          tcnt_n = '0;
        end else if (to_hit) begin
          clk_oe_n  = 1'b0;
          data_oe_n = 1'b0;
          error_n   = 1'b1;
          state_n   = S_IDLE;
        end else begin
          tcnt_n = TO_W'(tcnt + 1'b1);
        end
      end
      default: begin
        clk_oe_n  = 1'b0;
        data_oe_n = 1'b0;
        state_n   = S_IDLE;
      end
    endcase

    busy_n = (state_n != S_IDLE);
  end

  // State, counters, synchronizers and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state         <= S_IDLE;
      cnt           <= '0;
      tcnt          <= '0;
      bit_cnt       <= '0;
      frame         <= '0;
      o_ps2_clk_oe  <= 1'b0;
      o_ps2_data_oe <= 1'b0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_error       <= 1'b0;
      clk_s1        <= 1'b1;
      clk_s2        <= 1'b1;
      clk_prev      <= 1'b1;
      dat_s1        <= 1'b1;
      dat_s2        <= 1'b1;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      tcnt          <= tcnt_n;
      bit_cnt       <= bit_n;
      frame         <= frame_n;
      o_ps2_clk_oe  <= clk_oe_n;
      o_ps2_data_oe <= data_oe_n;
      o_busy        <= busy_n;
      o_done        <= done_n;
      o_error       <= error_n;
      clk_s1        <= i_ps2_clk;
      clk_s2        <= clk_s1;
      clk_prev      <= clk_s2;
      dat_s1        <= i_ps2_data;
      dat_s2        <= dat_s1;
    end
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter: the send side of the PS/2 link whose device-to-host side the mouse receiver already decodes.
- Sends one command byte to the mouse, e.g. 0xF4 (enable data reporting) or 0xFF (reset), using the standard host-to-device protocol.
- Controls the bus through open-drain enables; the top level ties PS2_CLK/PS2_DAT low when the matching enable is 1, else high-Z.
- o_busy gates the mouse receiver during transmission. Runs on CLOCK_50.

Parameters:
- INHIBIT_CYCLES, 5000: clock-low inhibit length before request-to-send (100 us at 50 MHz).
- RTS_CYCLES, 100: data-low overlap with clock-low before releasing clock (2 us).
- TIMEOUT_CYCLES, 750000: max wait for any expected device clock falling edge, or for bus idle (15 ms).

Ports:
- i_clk  in  1  system clock, 50 MHz.
- i_rst  in  1  synchronous reset, active-high.
- i_data  in  8  command byte; sampled when i_valid is accepted.
- i_valid  in  1  start request; accepted only in IDLE.
- o_busy  out  1  high in every state except IDLE.
- o_done  out  1  1-cycle pulse when the device acknowledges and the bus returns idle.
- o_error  out  1  1-cycle pulse on NACK or timeout.
- i_ps2_clk  in  1  raw PS/2 clock line (asynchronous).
- i_ps2_data  in  1  raw PS/2 data line (asynchronous).
- o_ps2_clk_oe  out  1  1 = pull clock low.
- o_ps2_data_oe  out  1  1 = pull data low.

Behaviour:
- Reset, synchronous and active-high: state IDLE; all outputs 0; counters 0; synchronizers set to 1. Reset asserted mid-transfer releases both lines on the next edge with no done/error pulse.
- Inputs pass through 2-flop synchronizers. A falling edge (fall) is detected when the synced previous value is 1 and the current value is 0. fall is 3 cycles behind the raw edge.
- Frame: shift register {stop=1, parity, data[7:0]}, shifted out LSB first. Parity is odd: parity = ~^data (0xF4 gives 0, 0xFF gives 1).
- IDLE: clk_oe=0, data_oe=0. If i_valid, latch the frame, clear counters, go to INHIBIT. o_busy rises the cycle after acceptance.
- INHIBIT: clk_oe=1 for exactly INHIBIT_CYCLES cycles, then data_oe=1 and go to RTS.
- RTS: clk_oe=1, data_oe=1 for RTS_CYCLES cycles; then clk_oe=0, data_oe stays 1 (start bit), bit_cnt=0, timeout counter cleared, go to SEND.
- SEND, on each fall:
  - bit_cnt 0..8: data_oe = ~frame[bit_cnt], so data is driven only for '0' bits.
  - bit_cnt 9: data_oe=0 (stop bit, line released); go to ACK.
  - bit_cnt increments on each fall. The device samples on its rising edges, so the data change on fall is in time.
- ACK: wait for the next fall. Sampled synced data 0 means ACK, go to WAIT_IDLE. Data 1 means NACK, pulse o_error and go to IDLE.
- WAIT_IDLE: wait until synced clock=1 and data=1 on the same cycle, then pulse o_done and go to IDLE.
- Timeout: in SEND, ACK and WAIT_IDLE, a counter is cleared on every fall (and on state entry) and increments otherwise. Reaching TIMEOUT_CYCLES releases both lines, pulses o_error, and returns to IDLE.
- i_valid while busy is ignored, not queued. o_done and o_error are never asserted together.
- A fall during INHIBIT or RTS is ignored.

Test Plan:
- Send 0xF4 with a device BFM (~12.5 kHz clock starting 50 us after clock release, ACK low on the 11th clock):
  - clk_oe high exactly 5000 cycles, then 100 cycles of clk_oe plus data_oe.
  - Device captures start 0, data 0,0,1,0,1,1,1,1, parity 0, stop 1.
  - o_done pulses once; o_busy falls the same cycle as the pulse.
- Send 0xFF -> device sees eight 1s with parity 1 and stop 1; o_done=1.
- BFM leaves data high on the 11th clock (NACK) -> single o_error pulse; both oe outputs 0; state IDLE.
- BFM never clocks after clock release -> o_error exactly TIMEOUT_CYCLES (750000) cycles after entering SEND; lines released.
- i_valid pulsed with 0x00 mid-transfer of 0xF4 -> ignored; only 0xF4 is transmitted; one o_done.
- i_rst asserted at bit 4 -> next cycle: oe=0, o_busy=0, no done/error. A following 0xF2 request completes normally.
